// File: rtl/asteroid_field.sv
// rtl/asteroid_field.sv - 16x16 asteroid occupancy grid generator with scroll, spawn and scoring
//
// Purpose:
//   Spawns pseudo-random asteroid rows at row 0 and scrolls the field toward
//   row 15 (the ship row) once per tick. Empty rows are inserted between
//   asteroid rows. Rows that leave row 15 non-empty are counted as dodged.
//   A collision indication on halt freezes the field until the next start.
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous active-low reset
//   start        in   one-cycle pulse, begins a new game from IDLE or FROZEN
//   halt         in   collision indication, freezes the field while in RUN
//   level[1:0]   in   speed select, tick period = BASE_PERIOD >> level
//   grid         out  occupancy grid[r][c], row 0 = spawn, row 15 = ship row
//   row_tick     out  one-cycle pulse the cycle after each scroll
//   rows_dodged  out  saturating count of non-empty rows scrolled off row 15
//   running      out  high while in RUN

module asteroid_field #(
  parameter int          BASE_PERIOD = 32,
  parameter int          GAP         = 1,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt,
  input  logic [1:0]        level,
  output logic [15:0][15:0] grid,
  output logic              row_tick,
  output logic [7:0]        rows_dodged,
  output logic              running
);

  localparam int         CW    = $clog2(BASE_PERIOD);
  localparam logic [CW:0] BP   = (CW+1)'(BASE_PERIOD);
  localparam logic [2:0] GAP_L = 3'(GAP);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FROZEN
  } state_t;

  state_t        state;
  state_t        state_n;
  logic          enter_run;
  logic [CW-1:0] cnt;
  logic [15:0]   lfsr;
  logic [2:0]    gap_cnt;
  logic [CW:0]   period_m1;
  logic          advance;
  logic          scroll;
  logic [15:0]   lfsr_rot;
  logic [15:0]   new_row;

  always_comb begin
    state_n   = state;
    enter_run = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n   = S_RUN;
          enter_run = 1'b1;
        end
      end
      S_RUN: begin
        if (halt) begin
          state_n = S_FROZEN;
        end
      end
      S_FROZEN: begin
        // start wins over a still-asserted halt here
        if (start) begin
          state_n   = S_RUN;
          enter_run = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // The period can shrink mid-count when level rises; the >= compare turns
  // that into a scroll on the next cycle instead of a counter wrap.
  assign period_m1 = (BP >> level) - (CW+1)'(1);
  assign advance   = (state == S_RUN) && !halt;
  assign scroll    = advance && ({1'b0, cnt} >= period_m1);

  assign lfsr_rot = {lfsr[8:0], lfsr[15:9]};
  assign new_row  = (gap_cnt != 3'd0) ? 16'h0000 : (lfsr & lfsr_rot);

  assign running = (state == S_RUN);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      grid        <= '0;
      row_tick    <= 1'b0;
      rows_dodged <= 8'd0;
      cnt         <= '0;
      lfsr        <= SEED;
      gap_cnt     <= GAP_L;
    end else begin
      state    <= state_n;
      row_tick <= scroll;
      if (enter_run) begin
        grid        <= '0;
        rows_dodged <= 8'd0;
        cnt         <= '0;
        lfsr        <= SEED;
        gap_cnt     <= GAP_L;
      end else if (advance) begin
        if (scroll) begin
          cnt  <= '0;
          grid <= {grid[14:0], new_row};
          if ((grid[15] != 16'h0000) && (rows_dodged != 8'hFF)) begin
            rows_dodged <= rows_dodged + 8'd1;
          end
          if (gap_cnt != 3'd0) begin
            gap_cnt <= gap_cnt - 3'd1;
          end else begin
            // LFSR only steps on rows that actually carry asteroids
            lfsr    <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            gap_cnt <= GAP_L;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_asteroid_field.sv
// tb/tb_asteroid_field.sv - directed scoreboard bench for asteroid_field

module tb_asteroid_field;

  localparam logic [15:0] TB_SEED = 16'hACE1;
  localparam int          TB_GAP  = 1;

  logic              clk;
  logic              reset;
  logic              start;
  logic              halt;
  logic [1:0]        level;
  logic [15:0][15:0] grid;
  logic              row_tick;
  logic [7:0]        rows_dodged;
  logic              running;

  int checks;
  int failures;

  typedef struct packed {
    logic [255:0] g;
    logic [7:0]   s;
  } exp_t;

  exp_t sbq[$];

  logic [15:0][15:0] m_grid;
  logic [15:0]       m_lfsr;
  int                m_gap;
  int                m_score;

  asteroid_field #(
    .BASE_PERIOD(8),
    .GAP(TB_GAP),
    .SEED(TB_SEED)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .halt(halt),
    .level(level),
    .grid(grid),
    .row_tick(row_tick),
    .rows_dodged(rows_dodged),
    .running(running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_grid  = '0;
    m_lfsr  = TB_SEED;
    m_gap   = TB_GAP;
    m_score = 0;
    sbq.delete();
  endtask

  // Independent model of one scroll; pushes the expected post-scroll state.
  task automatic model_scroll();
    logic [15:0] r;
    logic [15:0] rot;
    exp_t        e;
    if (m_grid[15] != 16'h0 && m_score < 255) m_score++;
    if (m_gap != 0) begin
      r = 16'h0;
      m_gap--;
    end else begin
      rot    = {m_lfsr[8:0], m_lfsr[15:9]};
      r      = m_lfsr & rot;
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      m_gap  = TB_GAP;
    end
    m_grid = {m_grid[14:0], r};
    e.g = m_grid;
    e.s = 8'(m_score);
    sbq.push_back(e);
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    checks++;
    assert (row_tick === 1'b1 && sbq.size() > 0) else begin
      failures++;
      $error("FAIL %s_tick observed=%0b expected=1 (queue=%0d)", tag, row_tick, sbq.size());
    end
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk({tag, "_grid"}, grid, e.g);
      chk({tag, "_score"}, {248'd0, rows_dodged}, {248'd0, e.s});
    end
  endtask

  task automatic wait_scroll(input int exp_cycles, input string tag);
    int n;
    n = 0;
    while (n < 50) begin
      step();
      n++;
      if (row_tick === 1'b1) break;
    end
    chk({tag, "_period"}, 256'(n), 256'(exp_cycles));
    pop_cmp(tag);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    logic seen_tick;
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    start    = 1'b0;
    halt     = 1'b0;
    level    = 2'd0;

    // Reset and idle
    repeat (3) step();
    chk("rst_grid", grid, 256'd0);
    chk("rst_running", 256'(running), 256'd0);
    chk("rst_tick", 256'(row_tick), 256'd0);
    chk("rst_score", 256'(rows_dodged), 256'd0);
    reset     = 1'b1;
    seen_tick = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (row_tick === 1'b1) seen_tick = 1'b1;
    end
    chk("idle_tick_seen", 256'(seen_tick), 256'd0);
    chk("idle_grid", grid, 256'd0);
    chk("idle_running", 256'(running), 256'd0);

    // Spawn sequence and scoring over 20 scrolls
    model_reset();
    for (int i = 0; i < 20; i++) model_scroll();
    pulse_start();
    chk("start_running", 256'(running), 256'd1);
    chk("start_tick", 256'(row_tick), 256'd0);
    for (int i = 0; i < 20; i++) begin
      wait_scroll(8, $sformatf("spawn%0d", i + 1));
      if (i == 1) begin
        chk("spawn2_row0", 256'(grid[0]), 256'h20C0);
        chk("spawn2_row1", 256'(grid[1]), 256'h0);
      end
      if (i == 2) begin
        chk("spawn3_row1", 256'(grid[1]), 256'h20C0);
        chk("spawn3_row2", 256'(grid[2]), 256'h0);
      end
      if (i == 16) chk("score_at17", 256'(rows_dodged), 256'd0);
      if (i == 17) chk("score_at18", 256'(rows_dodged), 256'd1);
    end

    // Halt on the cycle a scroll is due
    repeat (7) step();
    halt = 1'b1;
    step();
    chk("halt_running", 256'(running), 256'd0);
    chk("halt_grid", grid, m_grid);
    chk("halt_score", 256'(rows_dodged), 256'(m_score));
    chk("halt_tick", 256'(row_tick), 256'd0);
    repeat (10) step();
    chk("frozen_grid", grid, m_grid);
    chk("frozen_running", 256'(running), 256'd0);

    // start with halt still high restarts the game
    start = 1'b1;
    step();
    start = 1'b0;
    halt  = 1'b0;
    chk("restart_running", 256'(running), 256'd1);
    chk("restart_grid", grid, 256'd0);
    chk("restart_score", 256'(rows_dodged), 256'd0);
    model_reset();

    // Level switch 0 -> 2 with cnt at 5, then level 3
    repeat (5) step();
    level = 2'd2;
    model_scroll();
    step();
    pop_cmp("lvl_switch");
    model_scroll();
    model_scroll();
    wait_scroll(2, "lvl2_a");
    wait_scroll(2, "lvl2_b");
    level = 2'd3;
    for (int i = 0; i < 3; i++) model_scroll();
    for (int i = 0; i < 3; i++) wait_scroll(1, $sformatf("lvl3_%0d", i));

    // Reset on a scroll cycle after 10 scrolls
    halt = 1'b1;
    step();
    halt  = 1'b0;
    level = 2'd0;
    model_reset();
    for (int i = 0; i < 10; i++) model_scroll();
    pulse_start();
    for (int i = 0; i < 10; i++) wait_scroll(8, $sformatf("pre_rst%0d", i + 1));
    repeat (7) step();
    reset = 1'b0;
    step();
    chk("midrst_grid", grid, 256'd0);
    chk("midrst_running", 256'(running), 256'd0);
    chk("midrst_score", 256'(rows_dodged), 256'd0);
    chk("midrst_tick", 256'(row_tick), 256'd0);
    reset = 1'b1;
    repeat (10) step();
    chk("postrst_idle_running", 256'(running), 256'd0);
    chk("postrst_idle_grid", grid, 256'd0);
    model_reset();
    for (int i = 0; i < 3; i++) model_scroll();
    pulse_start();
    for (int i = 0; i < 3; i++) wait_scroll(8, $sformatf("replay%0d", i + 1));
    chk("replay_row1", 256'(grid[1]), 256'h20C0);
    chk("replay_row0", 256'(grid[0]), 256'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
